// File: rtl/flow_state_rd_mem.sv
// Per-flow state store: one synchronous read port with a val/rdy response
// handshake and one write port. It zeroes every entry after reset, and it
// forwards writes into in-flight or held responses so that readers never
// see stale state.
module flow_state_rd_mem #(
    parameter int FLOWID_W = 3,
    parameter int DATA_W   = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_req_val,
    input  logic [FLOWID_W-1:0] rd_req_flowid,
    output logic                rd_req_rdy,
    output logic                rd_resp_val,
    output logic [DATA_W-1:0]   rd_resp_data,
    input  logic                rd_resp_rdy,
    input  logic                wr_req_val,
    input  logic [FLOWID_W-1:0] wr_req_flowid,
    input  logic [DATA_W-1:0]   wr_req_data,
    output logic                wr_req_rdy,
    output logic                init_done
);

    localparam int DEPTH = 1 << FLOWID_W;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [FLOWID_W:0]   init_addr_q, init_addr_d, init_addr_inc;
    logic                init_done_q, init_done_d;
    logic                rd_resp_val_q, rd_resp_val_d;
    logic                wr_req_rdy_q, wr_req_rdy_d;
    logic                first_q, first_d;       // first cycle of a response: data comes from the RAM read
    logic                byp_q, byp_d;           // same-cycle write hit on the read just accepted
    logic [FLOWID_W-1:0] resp_flowid_q, resp_flowid_d;
    logic [DATA_W-1:0]   byp_data_q, byp_data_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic [DATA_W-1:0]   ram_rd_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                rd_fire, wr_fire, held_hit;
    logic                mem_we;
    logic [FLOWID_W-1:0] mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   first_data, cur_data;

    // A new request is taken when idle, or when the current response leaves in the same cycle
    assign rd_req_rdy    = (state_q == ST_IDLE) | ((state_q == ST_RESP) & rd_resp_rdy);
    assign rd_fire       = rd_req_val & rd_req_rdy;
    assign wr_fire       = wr_req_val & wr_req_rdy_q;
    assign held_hit      = rd_resp_val_q & ~rd_resp_rdy & wr_fire & (wr_req_flowid == resp_flowid_q);
    assign init_addr_inc = init_addr_q + {{FLOWID_W{1'b0}}, 1'b1};

    assign first_data    = byp_q ? byp_data_q : ram_rd_q;
    assign cur_data      = first_q ? first_data : hold_q;

    assign rd_resp_val   = rd_resp_val_q;
    assign rd_resp_data  = rd_resp_val_q ? cur_data : '0;
    assign wr_req_rdy    = wr_req_rdy_q;
    assign init_done     = init_done_q;

    // Next-state and registered-output logic for the INIT/IDLE/RESP controller
    always_comb begin
        state_d       = state_q;
        init_addr_d   = init_addr_q;
        init_done_d   = init_done_q;
        rd_resp_val_d = rd_resp_val_q;
        wr_req_rdy_d  = wr_req_rdy_q;
        first_d       = rd_fire;
        byp_d         = rd_fire & wr_fire & (wr_req_flowid == rd_req_flowid);
        case (state_q)
            ST_INIT: begin
                init_addr_d = init_addr_inc;
                if (init_addr_inc[FLOWID_W]) begin
                    state_d      = ST_IDLE;
                    init_done_d  = 1'b1;
                    wr_req_rdy_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (rd_fire) begin
                    state_d       = ST_RESP;
                    rd_resp_val_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (rd_resp_rdy && !rd_req_val) begin
                    state_d       = ST_IDLE;
                    rd_resp_val_d = 1'b0;
                end
            end
            default: begin
                state_d       = ST_INIT;
                init_addr_d   = '0;
                init_done_d   = 1'b0;
                rd_resp_val_d = 1'b0;
                wr_req_rdy_d  = 1'b0;
            end
        endcase
    end

    // Response datapath: captured flow id, same-cycle bypass data and holding register
    always_comb begin
        resp_flowid_d = rd_fire ? rd_req_flowid : resp_flowid_q;
        byp_data_d    = byp_d ? wr_req_data : byp_data_q;
        hold_d        = hold_q;
        if (held_hit) begin
            hold_d = wr_req_data;
        end else if (rd_resp_val_q && first_q) begin
            hold_d = first_data;
        end
    end

    // RAM write port: zero fill while initialising, otherwise accepted writes
    always_comb begin
        mem_we    = wr_fire;
        mem_waddr = wr_req_flowid;
        mem_wdata = wr_req_data;
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = init_addr_q[FLOWID_W-1:0];
            mem_wdata = '0;
        end
    end

    // Controller state; reset returns to INIT and drops any response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_INIT;
            init_addr_q   <= '0;
            init_done_q   <= 1'b0;
            rd_resp_val_q <= 1'b0;
            wr_req_rdy_q  <= 1'b0;
            first_q       <= 1'b0;
            byp_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_addr_q   <= init_addr_d;
            init_done_q   <= init_done_d;
            rd_resp_val_q <= rd_resp_val_d;
            wr_req_rdy_q  <= wr_req_rdy_d;
            first_q       <= first_d;
            byp_q         <= byp_d;
        end
    end

    // Response data registers carry no reset; the output is masked while no response is valid
    always_ff @(posedge clk) begin
        resp_flowid_q <= resp_flowid_d;
        byp_data_q    <= byp_data_d;
        hold_q        <= hold_d;
    end

    // Storage array with separate write and synchronous read ports
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (rd_fire) begin
            ram_rd_q <= mem[rd_req_flowid];
        end
    end

endmodule

// File: tb/tb_flow_state_rd_mem.sv
// Scoreboard bench for flow_state_rd_mem: stimulus pushes expected
// responses, a monitor compares every presented response.
module tb_flow_state_rd_mem;

    localparam int FW = 3;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_req_val;
    logic [FW-1:0] rd_req_flowid;
    logic          rd_req_rdy;
    logic          rd_resp_val;
    logic [DW-1:0] rd_resp_data;
    logic          rd_resp_rdy;
    logic          wr_req_val;
    logic [FW-1:0] wr_req_flowid;
    logic [DW-1:0] wr_req_data;
    logic          wr_req_rdy;
    logic          init_done;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_q[$];

    flow_state_rd_mem #(.FLOWID_W(FW), .DATA_W(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .rd_req_val    (rd_req_val),
        .rd_req_flowid (rd_req_flowid),
        .rd_req_rdy    (rd_req_rdy),
        .rd_resp_val   (rd_resp_val),
        .rd_resp_data  (rd_resp_data),
        .rd_resp_rdy   (rd_resp_rdy),
        .wr_req_val    (wr_req_val),
        .wr_req_flowid (wr_req_flowid),
        .wr_req_data   (wr_req_data),
        .wr_req_rdy    (wr_req_rdy),
        .init_done     (init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; drives one cycle of requests and records the expected response
    task automatic issue(input logic do_rd, input logic [FW-1:0] rf, input logic [DW-1:0] rexp,
                         input logic do_wr, input logic [FW-1:0] wf, input logic [DW-1:0] wd,
                         input string name);
        logic racc;
        logic wacc;
        rd_req_val    = do_rd;
        rd_req_flowid = rf;
        wr_req_val    = do_wr;
        wr_req_flowid = wf;
        wr_req_data   = wd;
        @(negedge clk);
        racc = rd_req_rdy;
        wacc = wr_req_rdy;
        if (do_rd) chk({name, "_rd_acc"}, 64'(racc), 64'd1);
        if (do_wr) chk({name, "_wr_acc"}, 64'(wacc), 64'd1);
        @(posedge clk);
        if (do_rd && racc) exp_q.push_back(rexp);
        #1;
        rd_req_val = 1'b0;
        wr_req_val = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Response monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && rd_resp_val) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected: got data %0h, expected no response", rd_resp_data);
                end else begin
                    chk("resp_data", rd_resp_data, exp_q[0]);
                    if (rd_resp_rdy) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    logic          sv  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [FW-1:0] sf  [7] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd0};
    logic [DW-1:0] se  [7] = '{64'h0101, 64'h2222, 64'h4444, 64'h4444, 64'h4444, 64'h4444, 64'h0};
    logic          srr [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic          srdy[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        int n_acc;
        int n;
        logic acc;
        rst           = 1'b1;
        rd_req_val    = 1'b0;
        rd_req_flowid = '0;
        wr_req_val    = 1'b0;
        wr_req_flowid = '0;
        wr_req_data   = '0;
        rd_resp_rdy   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_rd_req_rdy",   64'(rd_req_rdy),  64'd0);
        chk("rst_rd_resp_val",  64'(rd_resp_val), 64'd0);
        chk("rst_wr_req_rdy",   64'(wr_req_rdy),  64'd0);
        chk("rst_init_done",    64'(init_done),   64'd0);
        chk("rst_rd_resp_data", rd_resp_data,     64'd0);

        // Init: requests during INIT must be ignored
        @(posedge clk);
        #1;
        rst           = 1'b0;
        rd_req_val    = 1'b1;
        rd_req_flowid = 3'd0;
        wr_req_val    = 1'b1;
        wr_req_flowid = 3'd1;
        wr_req_data   = 64'hDEAD;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("init_done_low",  64'(init_done),  64'd0);
            chk("init_rd_rdy",    64'(rd_req_rdy), 64'd0);
            chk("init_wr_rdy",    64'(wr_req_rdy), 64'd0);
        end
        rd_req_val = 1'b0;
        wr_req_val = 1'b0;
        @(negedge clk);
        chk("init_done_high", 64'(init_done),  64'd1);
        chk("idle_rd_rdy",    64'(rd_req_rdy), 64'd1);
        @(posedge clk);
        #1;
        for (int f = 0; f < 8; f++) issue(1'b1, FW'(f), 64'd0, 1'b0, 3'd0, 64'd0, "init_rd");

        // Basic write then read
        issue(1'b0, 3'd0, 64'd0, 1'b1, 3'd5, 64'hABCD, "wr5");
        issue(1'b1, 3'd5, 64'hABCD, 1'b0, 3'd0, 64'd0, "rd5");
        issue(1'b1, 3'd4, 64'd0,    1'b0, 3'd0, 64'd0, "rd4");

        // Same-cycle forwarding
        issue(1'b0, 3'd0, 64'd0, 1'b1, 3'd2, 64'h1111, "wr2");
        issue(1'b1, 3'd2, 64'h2222, 1'b1, 3'd2, 64'h2222, "fwd_same");

        // Held-response forwarding
        issue(1'b0, 3'd0, 64'd0, 1'b1, 3'd3, 64'h0033, "wr3");
        idle(2);
        rd_resp_rdy = 1'b0;
        issue(1'b1, 3'd3, 64'h0033, 1'b0, 3'd0, 64'd0,    "hold_rd");
        issue(1'b0, 3'd0, 64'd0,    1'b1, 3'd6, 64'h6666, "hold_wr6");
        issue(1'b0, 3'd0, 64'd0,    1'b1, 3'd3, 64'h4444, "hold_wr3");
        if (exp_q.size() == 1) begin
            exp_q[0] = 64'h4444;
        end else begin
            chk("hold_queue_len", 64'(exp_q.size()), 64'd1);
        end
        @(negedge clk);
        chk("hold_rd_rdy", 64'(rd_req_rdy), 64'd0);
        @(posedge clk);
        #1;
        rd_resp_rdy = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b1, 3'd6, 64'h6666, 1'b0, 3'd0, 64'd0, "rd6");
        issue(1'b1, 3'd3, 64'h4444, 1'b0, 3'd0, 64'd0, "rd3");

        // Back-to-back reads with a stall on the second response
        issue(1'b0, 3'd0, 64'd0, 1'b1, 3'd1, 64'h0101, "wr1");
        n_acc = 0;
        for (int t = 0; t < 7; t++) begin
            rd_req_val    = sv[t];
            rd_req_flowid = sf[t];
            rd_resp_rdy   = srr[t];
            @(negedge clk);
            chk("stall_rd_rdy", 64'(rd_req_rdy), 64'(srdy[t]));
            acc = sv[t] & rd_req_rdy;
            @(posedge clk);
            if (acc) begin
                exp_q.push_back(se[t]);
                n_acc++;
            end
            #1;
        end
        rd_req_val = 1'b0;
        chk("stall_accepts", 64'(n_acc), 64'd3);
        idle(2);
        chk("stall_drained", 64'(exp_q.size()), 64'd0);

        // Reset while a response is held
        rd_resp_rdy = 1'b0;
        issue(1'b1, 3'd5, 64'hABCD, 1'b0, 3'd0, 64'd0, "rst_rd");
        idle(1);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst         = 1'b0;
        rd_resp_rdy = 1'b1;
        @(negedge clk);
        chk("rst_mid_resp_val",  64'(rd_resp_val), 64'd0);
        chk("rst_mid_resp_data", rd_resp_data,     64'd0);
        chk("rst_mid_init_done", 64'(init_done),   64'd0);
        n = 0;
        while (!init_done && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reinit_len", 64'(n), 64'd8);
        issue(1'b1, 3'd5, 64'd0, 1'b0, 3'd0, 64'd0, "post_rst_rd5");
        issue(1'b1, 3'd3, 64'd0, 1'b0, 3'd0, 64'd0, "post_rst_rd3");
        idle(3);
        chk("final_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
